// File: rtl/rgb_wheel_fader.sv
// Multi-channel colour-wheel fader with integrated PWM; duty updates only at PWM period boundaries.
// Define RGB_WHEEL_FADER_ACTIVE_LOW_EN to invert pwm_out for common-anode LEDs.
module rgb_wheel_fader #(
    parameter int NUM_CH        = 3,
    parameter int PWM_INTERVAL  = 1200,
    parameter int STEP_INTERVAL = 12000,
    parameter int STEPS_PER_SEG = 200,
    localparam int INC_VAL      = PWM_INTERVAL / STEPS_PER_SEG,
    localparam int FULL         = INC_VAL * STEPS_PER_SEG,
    localparam int PW           = $clog2(PWM_INTERVAL + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic [NUM_CH-1:0]    pwm_out,
    output logic [NUM_CH*PW-1:0] level,
    output logic [2:0]           seg,
    output logic                 step_tick
);

    localparam int SCW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
    localparam int KW  = (STEPS_PER_SEG > 1) ? $clog2(STEPS_PER_SEG) : 1;

`ifdef RGB_WHEEL_FADER_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic [SCW-1:0] step_cnt;
    logic [KW-1:0]  k;
    logic [PW-1:0]  pwm_cnt;
    logic [PW-1:0]  level_r [NUM_CH];
    logic [PW-1:0]  target  [NUM_CH];
    logic [PW-1:0]  ramp;
    logic [3:0]     s;

    wire step_last = (step_cnt == SCW'(STEP_INTERVAL - 1));
    wire pwm_last  = (pwm_cnt == PW'(PWM_INTERVAL - 1));

    // Each channel reads the wheel at its own segment offset; ramps share the k index.
    always_comb begin
        ramp = PW'(k) * PW'(INC_VAL);
        s    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            s = {1'b0, seg} + 4'((2 * i) % 6);
            if (s >= 4'd6)
                s = s - 4'd6;
            case (s)
                4'd0, 4'd1: target[i] = PW'(FULL);
                4'd2:       target[i] = PW'(FULL) - ramp;
                4'd5:       target[i] = ramp;
                default:    target[i] = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt  <= '0;
            k         <= '0;
            seg       <= '0;
            step_tick <= 1'b0;
        end else begin
            step_tick <= en && step_last;
            if (en) begin
                if (step_last) begin
                    step_cnt <= '0;
                    if (k == KW'(STEPS_PER_SEG - 1)) begin
                        k   <= '0;
                        seg <= (seg == 3'd5) ? 3'd0 : seg + 3'd1;
                    end else begin
                        k <= k + KW'(1);
                    end
                end else begin
                    step_cnt <= step_cnt + SCW'(1);
                end
            end
        end
    end

    // Levels latch only on the period boundary so a running period is never cut short.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            pwm_out <= {NUM_CH{INV}};
            for (int i = 0; i < NUM_CH; i++)
                level_r[i] <= '0;
        end else begin
            pwm_cnt <= pwm_last ? '0 : pwm_cnt + PW'(1);
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_out[i] <= (pwm_cnt < level_r[i]) ^ INV;
                if (pwm_last)
                    level_r[i] <= target[i];
            end
        end
    end

    always_comb begin
        level = '0;
        for (int i = 0; i < NUM_CH; i++)
            level[i*PW +: PW] = level_r[i];
    end

endmodule
